// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin (or fixed B-priority) arbiter/sequencer for two requesters sharing the single-port data memory.
// Latency: request accepted at cycle N, memory driven at N+1, response valid at N+2; initiation interval 3 cycles.
// Backpressure: one request in flight; a response held by rready=0 stalls in RESP and blocks both requesters.
// Ports: i_clk/i_reset; per requester (a = instruction fetch, b = load/store unit): request valid/ready/addr/wdata/bmask/wren
//        and response rvalid/rready/rdata/rerr; o_mem_addr/wdata/bmask/wren to memory, i_mem_rdata from memory; o_busy.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_a_valid,
    output logic              o_a_ready,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [31:0]       i_a_wdata,
    input  logic [2:0]        i_a_bmask,
    input  logic              i_a_wren,
    output logic              o_a_rvalid,
    input  logic              i_a_rready,
    output logic [31:0]       o_a_rdata,
    output logic              o_a_rerr,

    input  logic              i_b_valid,
    output logic              o_b_ready,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [31:0]       i_b_wdata,
    input  logic [2:0]        i_b_bmask,
    input  logic              i_b_wren,
    output logic              o_b_rvalid,
    input  logic              i_b_rready,
    output logic [31:0]       o_b_rdata,
    output logic              o_b_rerr,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [2:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata,

    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched request and response registers
    logic              last_b;      // 1 = B was granted most recently
    logic              owner_b;     // 1 = request in flight belongs to B
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        bmask_q;
    logic              wren_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              a_win;
    logic              b_win;
    logic              accept;
    logic              owner_rready;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_bmask;
    logic              sel_wren;
    logic              sel_err;

    // Illegal size codes, misaligned halves/words, and stores using the unsigned load codes
    function automatic logic req_illegal(input logic [1:0] lsb, input logic [2:0] bmask, input logic wren);
        logic bad;
        bad = 1'b0;
        case (bmask)
            3'b000, 3'b011: bad = 1'b0;
            3'b001, 3'b100: bad = lsb[0];
            3'b010:         bad = |lsb;
            default:        bad = 1'b1;
        endcase
        if (wren && (bmask == 3'b011 || bmask == 3'b100)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // A wins when alone, or on a tie when round-robin is on and B had the last grant
    assign a_win  = i_a_valid && (!i_b_valid || (RR_EN && last_b));
    assign b_win  = i_b_valid && !a_win;
    assign accept = (state == S_IDLE) && (a_win || b_win);

    assign sel_addr  = b_win ? i_b_addr  : i_a_addr;
    assign sel_wdata = b_win ? i_b_wdata : i_a_wdata;
    assign sel_bmask = b_win ? i_b_bmask : i_a_bmask;
    assign sel_wren  = b_win ? i_b_wren  : i_a_wren;
    assign sel_err   = req_illegal(sel_addr[1:0], sel_bmask, sel_wren);

    assign owner_rready = owner_b ? i_b_rready : i_a_rready;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   if (owner_rready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request latch, grant history and response capture
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_b  <= 1'b1;
            owner_b <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
            wren_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                bmask_q <= sel_bmask;
                wren_q  <= sel_wren;
                err_q   <= sel_err;
                owner_b <= b_win;
                last_b  <= b_win;
            end
            if (state == S_ACCESS) begin
                // Stores and rejected requests return zero data
                rdata_q <= (wren_q || err_q) ? 32'h0 : i_mem_rdata;
            end
        end
    end

    // Outputs; write enable is decoded from state so an async reset kills it immediately
    always_comb begin
        o_a_ready  = 1'b0;
        o_b_ready  = 1'b0;
        o_a_rvalid = 1'b0;
        o_b_rvalid = 1'b0;
        o_a_rdata  = 32'h0;
        o_b_rdata  = 32'h0;
        o_a_rerr   = 1'b0;
        o_b_rerr   = 1'b0;
        o_mem_wren = 1'b0;
        o_busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                o_a_ready = a_win;
                o_b_ready = b_win;
            end
            S_ACCESS: begin
                o_mem_wren = wren_q && !err_q;
            end
            S_RESP: begin
                if (owner_b) begin
                    o_b_rvalid = 1'b1;
                    o_b_rdata  = rdata_q;
                    o_b_rerr   = err_q;
                end else begin
                    o_a_rvalid = 1'b1;
                    o_a_rdata  = rdata_q;
                    o_a_rerr   = err_q;
                end
            end
            default: ;
        endcase
    end

    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_bmask = bmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a byte-lane memory model behind the memory port.
// Request drivers per port pop from queues; expected responses are queued by the stimulus and checked by a monitor.
// A second instance with fixed priority checks that B wins every tie.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid, a_ready, a_wren, a_rvalid, a_rready, a_rerr;
    logic [15:0] a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic [2:0]  a_bmask;
    logic        b_valid, b_ready, b_wren, b_rvalid, b_rready, b_rerr;
    logic [15:0] b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [2:0]  b_bmask;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  mem_bmask;
    logic        mem_wren, busy;

    mem_arbiter #(.ADDR_W(16), .RR_EN(1'b1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .i_a_bmask(a_bmask), .i_a_wren(a_wren), .o_a_rvalid(a_rvalid), .i_a_rready(a_rready),
        .o_a_rdata(a_rdata), .o_a_rerr(a_rerr),
        .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .i_b_bmask(b_bmask), .i_b_wren(b_wren), .o_b_rvalid(b_rvalid), .i_b_rready(b_rready),
        .o_b_rdata(b_rdata), .o_b_rerr(b_rerr),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
        .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    // Fixed-priority instance; its memory returns the address as data
    logic        fp_a_valid, fp_a_ready, fp_a_rvalid, fp_a_rerr;
    logic        fp_b_valid, fp_b_ready, fp_b_rvalid, fp_b_rerr;
    logic [31:0] fp_a_rdata, fp_b_rdata, fp_mem_wdata, fp_mem_rdata;
    logic [15:0] fp_mem_addr;
    logic [2:0]  fp_mem_bmask;
    logic        fp_mem_wren, fp_busy;
    assign fp_mem_rdata = {16'h0, fp_mem_addr};

    mem_arbiter #(.ADDR_W(16), .RR_EN(1'b0)) dut_fp (
        .i_clk(clk), .i_reset(rst),
        .i_a_valid(fp_a_valid), .o_a_ready(fp_a_ready), .i_a_addr(16'h0000), .i_a_wdata(32'h0),
        .i_a_bmask(3'b010), .i_a_wren(1'b0), .o_a_rvalid(fp_a_rvalid), .i_a_rready(1'b1),
        .o_a_rdata(fp_a_rdata), .o_a_rerr(fp_a_rerr),
        .i_b_valid(fp_b_valid), .o_b_ready(fp_b_ready), .i_b_addr(16'h0004), .i_b_wdata(32'h0),
        .i_b_bmask(3'b010), .i_b_wren(1'b0), .o_b_rvalid(fp_b_rvalid), .i_b_rready(1'b1),
        .o_b_rdata(fp_b_rdata), .o_b_rerr(fp_b_rerr),
        .o_mem_addr(fp_mem_addr), .o_mem_wdata(fp_mem_wdata), .o_mem_bmask(fp_mem_bmask),
        .o_mem_wren(fp_mem_wren), .i_mem_rdata(fp_mem_rdata), .o_busy(fp_busy)
    );

    // Memory model: word array, lane selection and extension by size code
    logic [31:0] mem_w [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;
    logic [31:0] mw;
    logic [7:0]  mb;
    logic [15:0] mh;

    always_comb begin
        mw = mem_w[mem_addr[9:2]];
        mb = mw[{mem_addr[1:0], 3'b000} +: 8];
        mh = mem_addr[1] ? mw[31:16] : mw[15:0];
        case (mem_bmask)
            3'b000:  mem_rdata = {{24{mb[7]}}, mb};
            3'b001:  mem_rdata = {{16{mh[15]}}, mh};
            3'b011:  mem_rdata = {24'h0, mb};
            3'b100:  mem_rdata = {16'h0, mh};
            default: mem_rdata = mw;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) begin
            mem_w[pl_idx] <= pl_val;
        end else if (mem_wren) begin
            case (mem_bmask)
                3'b000:  mem_w[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                3'b001:  mem_w[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                default: mem_w[mem_addr[9:2]] <= mem_wdata;
            endcase
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [2:0]  bmask;
        logic        wren;
    } req_t;
    typedef struct packed {
        logic        port_b;
        logic [31:0] rdata;
        logic        rerr;
    } rsp_t;

    req_t req_a_q[$];
    req_t req_b_q[$];
    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wren_cnt = 0;
    int   rvalid_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_rsp(input logic pb, input logic [31:0] d, input logic e);
        rsp_t x;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: port_b %0d rdata 0x%0h rerr %0d, required no response", pb, d, e);
        end else begin
            x = exp_q.pop_front();
            check("rsp_port_b", {63'h0, pb}, {63'h0, x.port_b});
            check("rsp_rdata", {32'h0, d}, {32'h0, x.rdata});
            check("rsp_rerr", {63'h0, e}, {63'h0, x.rerr});
        end
    endtask

    task automatic send(input logic pb, input logic [15:0] ad, input logic [31:0] wd, input logic [2:0] bm, input logic wr);
        req_t r;
        r = '{addr: ad, wdata: wd, bmask: bm, wren: wr};
        if (pb) req_b_q.push_back(r);
        else    req_a_q.push_back(r);
    endtask

    task automatic expect_rsp(input logic pb, input logic [31:0] d, input logic e);
        rsp_t x;
        x = '{port_b: pb, rdata: d, rerr: e};
        exp_q.push_back(x);
    endtask

    // Request drivers: handshake seen mid-cycle, payload advanced just after the edge
    logic a_hs = 1'b0;
    logic b_hs = 1'b0;
    always @(negedge clk) begin
        a_hs <= a_valid && a_ready;
        b_hs <= b_valid && b_ready;
    end

    initial begin
        a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_bmask = '0; a_wren = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (a_valid && a_hs) a_valid = 1'b0;
            if (!a_valid && req_a_q.size() > 0) begin
                req_t r;
                r = req_a_q.pop_front();
                a_addr = r.addr; a_wdata = r.wdata; a_bmask = r.bmask; a_wren = r.wren;
                a_valid = 1'b1;
            end
        end
    end

    initial begin
        b_valid = 1'b0; b_addr = '0; b_wdata = '0; b_bmask = '0; b_wren = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (b_valid && b_hs) b_valid = 1'b0;
            if (!b_valid && req_b_q.size() > 0) begin
                req_t r;
                r = req_b_q.pop_front();
                b_addr = r.addr; b_wdata = r.wdata; b_bmask = r.bmask; b_wren = r.wren;
                b_valid = 1'b1;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (a_rvalid && a_rready) check_rsp(1'b0, a_rdata, a_rerr);
            if (b_rvalid && b_rready) check_rsp(1'b1, b_rdata, b_rerr);
            if (mem_wren) wren_cnt++;
            if (a_rvalid || b_rvalid) rvalid_cnt++;
            if (busy) check("ready_outside_idle", {62'h0, a_ready, b_ready}, 64'h0);
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        pl_idx = idx; pl_val = val; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (req_a_q.size() == 0) && (req_b_q.size() == 0)
                   && !a_valid && !b_valid && !busy;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: timed out with %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic wait_accept(input logic pb, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = pb ? (b_valid && b_ready) : (a_valid && a_ready);
        end
        check(name, {63'h0, found}, 64'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    int w0, rv0, fpa, fpb;

    initial begin
        rst = 1'b1; a_rready = 1'b1; b_rready = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        fp_a_valid = 1'b0; fp_b_valid = 1'b0;
        preload(8'd0, 32'hA5A5_A5A5);
        preload(8'd4, 32'h8000_00F0);
        preload(8'd8, 32'h0000_0000);
        preload(8'd12, 32'hCAFE_F00D);
        preload(8'd16, 32'h1111_1111);
        preload(8'd17, 32'h2222_2222);
        preload(8'd18, 32'h3333_3333);
        preload(8'd19, 32'h4444_4444);

        @(negedge clk);
        check("reset_ctrl_outputs", {56'h0, a_ready, b_ready, a_rvalid, b_rvalid, a_rerr, b_rerr, mem_wren, busy}, 64'h0);
        check("reset_rdata", {a_rdata, b_rdata}, 64'h0);
        check("reset_mem_bus", {13'h0, mem_addr, mem_wdata, mem_bmask}, 64'h0);
        rst = 1'b0;

        // Fixed priority: B wins four back-to-back ties, then A once B drops
        @(posedge clk); #1;
        fp_a_valid = 1'b1; fp_b_valid = 1'b1; fpa = 0; fpb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fp_a_ready) fpa++;
            if (fp_b_ready) fpb++;
        end
        check("fp_b_grants", 64'(fpb), 64'd4);
        check("fp_a_grants_while_b_valid", 64'(fpa), 64'd0);
        @(posedge clk); #1;
        fp_b_valid = 1'b0;
        @(negedge clk);
        check("fp_a_grant_after_b_drops", {63'h0, fp_a_ready}, 64'h1);
        @(posedge clk); #1;
        fp_a_valid = 1'b0;

        // Single signed-byte load with latency checks
        @(negedge clk);
        send(1'b0, 16'h0010, 32'h0, 3'b000, 1'b0);
        expect_rsp(1'b0, 32'hFFFF_FFF0, 1'b0);
        wait_accept(1'b0, "load_accept");
        @(negedge clk);
        check("load_n1_mem_addr", {48'h0, mem_addr}, 64'h0010);
        check("load_n1_wren", {63'h0, mem_wren}, 64'h0);
        @(negedge clk);
        check("load_n2_rvalid", {63'h0, a_rvalid}, 64'h1);
        wait_idle();

        // Word store then unsigned half load of the upper half
        w0 = wren_cnt;
        send(1'b1, 16'h0020, 32'h1234_5678, 3'b010, 1'b1);
        expect_rsp(1'b1, 32'h0, 1'b0);
        wait_idle();
        check("store_wren_cycles", 64'(wren_cnt - w0), 64'd1);
        check("store_mem_word", {32'h0, mem_w[8]}, 64'h1234_5678);
        send(1'b1, 16'h0022, 32'h0, 3'b100, 1'b0);
        expect_rsp(1'b1, 32'h0000_1234, 1'b0);
        wait_idle();

        // Round-robin tie: last grant was B, so A, B, A, B
        send(1'b0, 16'h0040, 32'h0, 3'b010, 1'b0);
        send(1'b0, 16'h0048, 32'h0, 3'b010, 1'b0);
        send(1'b1, 16'h0044, 32'h0, 3'b010, 1'b0);
        send(1'b1, 16'h004C, 32'h0, 3'b010, 1'b0);
        expect_rsp(1'b0, 32'h1111_1111, 1'b0);
        expect_rsp(1'b1, 32'h2222_2222, 1'b0);
        expect_rsp(1'b0, 32'h3333_3333, 1'b0);
        expect_rsp(1'b1, 32'h4444_4444, 1'b0);
        wait_idle();

        // Rejected requests: A misaligned word load, B misaligned half store, A store with unsigned code
        w0 = wren_cnt;
        send(1'b0, 16'h0013, 32'h0, 3'b010, 1'b0);
        send(1'b0, 16'h0000, 32'h0000_00FF, 3'b011, 1'b1);
        send(1'b1, 16'h0001, 32'h0000_BEEF, 3'b001, 1'b1);
        expect_rsp(1'b0, 32'h0, 1'b1);
        expect_rsp(1'b1, 32'h0, 1'b1);
        expect_rsp(1'b0, 32'h0, 1'b1);
        wait_idle();
        check("err_no_wren", 64'(wren_cnt - w0), 64'd0);
        check("err_mem_word0", {32'h0, mem_w[0]}, 64'hA5A5_A5A5);
        check("err_mem_word4", {32'h0, mem_w[4]}, 64'h8000_00F0);

        // Response backpressure on A while B waits
        a_rready = 1'b0;
        send(1'b0, 16'h0040, 32'h0, 3'b010, 1'b0);
        expect_rsp(1'b0, 32'h1111_1111, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clk);
                seen = a_rvalid;
            end
            check("bp_rvalid_reached", {63'h0, seen}, 64'h1);
        end
        send(1'b1, 16'h0044, 32'h0, 3'b010, 1'b0);
        expect_rsp(1'b1, 32'h2222_2222, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {30'h0, a_rvalid, b_ready, a_rdata}, {30'h0, 1'b1, 1'b0, 32'h1111_1111});
        end
        @(posedge clk); #1;
        a_rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_b_first_idle", {63'h0, b_valid && b_ready}, 64'h1);
        wait_idle();

        // Reset during the access cycle of a store
        send(1'b1, 16'h0030, 32'hDEAD_BEEF, 3'b010, 1'b1);
        wait_accept(1'b1, "rst_store_accept");
        @(negedge clk);
        check("rst_store_wren_in_access", {63'h0, mem_wren}, 64'h1);
        rv0 = rvalid_cnt;
        rst = 1'b1;
        #1;
        check("rst_async_ctrl", {56'h0, a_ready, b_ready, a_rvalid, b_rvalid, a_rerr, b_rerr, mem_wren, busy}, 64'h0);
        check("rst_async_mem_bus", {13'h0, mem_addr, mem_wdata, mem_bmask}, 64'h0);
        check("rst_async_rdata", {a_rdata, b_rdata}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_no_rvalid", 64'(rvalid_cnt - rv0), 64'd0);
        check("rst_mem_unchanged", {32'h0, mem_w[12]}, 64'hCAFE_F00D);

        // Last grant resets to B, so A takes the first tie afterwards
        send(1'b1, 16'h0044, 32'h0, 3'b010, 1'b0);
        send(1'b0, 16'h0040, 32'h0, 3'b010, 1'b0);
        expect_rsp(1'b0, 32'h1111_1111, 1'b0);
        expect_rsp(1'b1, 32'h2222_2222, 1'b0);
        wait_idle();

        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of the single-port data memory. It accepts load/store requests from requester A (instruction fetch) and requester B (load/store unit) over valid/ready handshakes, and grants one at a time using round-robin. It registers the granted request and drives the memory for exactly one access cycle, then returns the captured read data, or an acknowledge/error, on the granting port's response handshake. Misaligned or illegal requests are rejected without touching memory.

## Interface
- ADDR_W, 16, byte-address width; matches the memory address port.
- RR_EN, 1, 1 = round-robin; 0 = fixed priority, B always wins.
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_a_valid / i_b_valid  in  1  request valid.
- o_a_ready / o_b_ready  out  1  request accepted when valid && ready.
- i_a_addr / i_b_addr  in  ADDR_W  byte address.
- i_a_wdata / i_b_wdata  in  32  store data, low-aligned.
- i_a_bmask / i_b_bmask  in  3  size code: 000 byte signed, 001 half signed, 010 word, 011 byte unsigned, 100 half unsigned.
- i_a_wren / i_b_wren  in  1  1 = store, 0 = load.
- o_a_rvalid / o_b_rvalid  out  1  response valid.
- i_a_rready / i_b_rready  in  1  response consumed when rvalid && rready.
- o_a_rdata / o_b_rdata  out  32  load result; 0 for stores and errors.
- o_a_rerr / o_b_rerr  out  1  request rejected: misaligned or illegal.
- o_mem_addr  out  ADDR_W  to memory address.
- o_mem_wdata  out  32  to memory write data.
- o_mem_bmask  out  3  to memory byte mask.
- o_mem_wren  out  1  to memory write enable.
- i_mem_rdata  in  32  memory combinational read data.
- o_busy  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE. o_x_ready = 1 for the winning requester only, and only when it is valid. On acceptance, latch addr/wdata/bmask/wren, the owner (A or B) and the error flag, then go to ACCESS.
  - ACCESS. Drive the memory from the latched request for one cycle. o_mem_wren = latched wren && !err. Capture i_mem_rdata into the response register at the cycle end. rdata = 0 if the request is a store or an error. Go to RESP.
  - RESP. o_owner_rvalid = 1 with the registered rdata/rerr. When i_owner_rready = 1, go to IDLE. Otherwise hold all response outputs stable.
- Arbitration in IDLE:
  - If only one requester is valid, it wins.
  - If both are valid and RR_EN = 1, the requester not granted last wins. The last-grant register resets to B, so A wins the first tie.
  - If RR_EN = 0, B wins every tie.
  - The last-grant register updates only on acceptance.
- Error conditions; any one sets err:
  - bmask is 101, 110 or 111.
  - bmask is 001 or 100 with addr[0] = 1.
  - bmask is 010 with addr[1:0] != 0.
  - wren = 1 with bmask 011 or 100 (stores use only 000/001/010).
- Error requests take the same path and latency. No write occurs (o_mem_wren = 0), rerr = 1, rdata = 0.
- Idle memory outputs:
  - o_mem_wren = 0 in IDLE and RESP.
  - o_mem_addr, o_mem_wdata and o_mem_bmask hold the last latched values; they are don't-care while wren = 0.
- The non-owner port never sees rvalid. Its request stays pending: the requester must hold valid and its payload stable until ready.

## Timing
- Reset values: state IDLE; every o_x_ready, o_x_rvalid, o_x_rerr, o_mem_wren and o_busy = 0; every o_x_rdata = 0; o_mem_addr, o_mem_wdata, o_mem_bmask = 0; last-grant = B.
- Reset mid-transaction: go to IDLE immediately (asynchronous). The in-flight request is dropped with no response. o_mem_wren drops to 0 before the next edge, so no partial write occurs.
- Latency: acceptance at cycle N, memory access at N+1, rvalid at N+2.
- Minimum initiation interval is 3 cycles: RESP with rready = 1 at N+2 returns to IDLE at N+3.
- ready is combinational from valid and the arbitration state. It is never asserted outside IDLE.
- A held rready = 0 stalls indefinitely in RESP. Both requesters stay blocked.

## Test plan
- Single load:
  - Stimulus: preload word 0x8000_00F0 at address 0x0010. A issues a load of 0x0010, bmask 000.
  - Required: a_ready at N; mem addr 0x0010 with wren 0 at N+1; a_rvalid at N+2 with rdata 0xFFFF_FFF0 and rerr 0.
- Store then load:
  - Stimulus: B stores 0x1234_5678 to 0x0020 (bmask 010) and receives its ack (rdata 0). B then loads 0x0022 with bmask 100.
  - Required: b_rdata = 0x0000_1234. Exactly one cycle of o_mem_wren = 1 during the store.
- Tie with RR_EN = 1:
  - Stimulus: A and B both hold valid continuously for 4 requests.
  - Required: grant order A, B, A, B.
  - Repeat with RR_EN = 0. Required: B, B, B, B while B stays valid.
- Misaligned requests:
  - Stimulus: A loads word at 0x0013; B stores half at 0x0001; A stores with bmask 011.
  - Required: each returns rerr = 1 and rdata = 0, o_mem_wren never goes high, and memory contents are unchanged.
- Response backpressure:
  - Stimulus: hold a_rready = 0 for 5 cycles in RESP while B is valid.
  - Required: a_rvalid and a_rdata stay stable and b_ready stays 0. B is accepted in the first IDLE cycle after A's handshake.
- Mid-access reset:
  - Stimulus: assert i_reset during the ACCESS cycle of a store to 0x0030.
  - Required: o_mem_wren goes to 0 asynchronously, the word at 0x0030 is unchanged, all outputs hold reset values, and no rvalid is issued.
